qstage_ctrl_csr: RTL and testbench



---
 rtl/qstage_ctrl_csr.sv | 131 +++++++++++++
 tb/tb_qstage_ctrl_csr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qstage_ctrl_csr.sv
// Write master for qstage tables: software fills shadow ADDR/SEL/DATA through a
// 32-bit register port, then GO launches a burst of REPEAT+1 single-cycle stage writes.
module qstage_ctrl_csr #(
  parameter int A_WIDTH         = 4,
  parameter int D_WIDTH         = 64,
  parameter int PARTS_CNT       = 4,
  parameter int PARTS_CNT_WIDTH = $clog2(PARTS_CNT)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [7:0]                 csr_addr_i,
  input  logic                       csr_wr_i,
  input  logic [31:0]                csr_wrdata_i,
  input  logic                       csr_rd_i,
  output logic [31:0]                csr_rddata_o,
  output logic [A_WIDTH-1:0]         wr_addr_o,
  output logic [D_WIDTH-1:0]         wr_data_o,
  output logic [PARTS_CNT_WIDTH-1:0] wr_sel_o,
  output logic                       wr_en_o
);
  localparam int WORDS = (D_WIDTH + 31) / 32;
  localparam int DW    = WORDS * 32;
  localparam logic [DW-1:0] DMASK = {DW{1'b1}} >> (DW - D_WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic                auto_inc, run_auto, err;
  logic [7:0]          rep, cnt;
  logic [A_WIDTH-1:0]  sh_addr;
  logic [31:0]         sh_sel;
  logic [DW-1:0]       sh_data;
  logic [15:0]         commit;
  logic [31:0]         rd_val;

  logic ctrl_wr, go, sel_ok, busy;
  assign ctrl_wr = csr_wr_i && (csr_addr_i == 8'd0);
  assign go      = ctrl_wr && csr_wrdata_i[0];
  // Full 32-bit shadow so out-of-range selects are detected, not truncated.
  assign sel_ok  = sh_sel < 32'(PARTS_CNT);
  assign busy    = (state == RUN);

  // Shadow registers, commit counter and sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      auto_inc <= 1'b0;
      rep      <= '0;
      sh_addr  <= '0;
      sh_sel   <= '0;
      sh_data  <= '0;
      commit   <= '0;
      err      <= 1'b0;
    end else begin
      if (csr_wr_i) begin
        case (csr_addr_i)
          8'd0: begin
            auto_inc <= csr_wrdata_i[1];
            rep      <= csr_wrdata_i[15:8];
          end
          8'd1: sh_addr <= csr_wrdata_i[A_WIDTH-1:0];
          8'd2: sh_sel  <= csr_wrdata_i;
          default: ;
        endcase
        for (int k = 0; k < WORDS; k++)
          if (csr_addr_i == 8'(4 + k))
            sh_data[k*32 +: 32] <= csr_wrdata_i & DMASK[k*32 +: 32];
      end
      if (wr_en_o) commit <= commit + 16'd1;
      // Set has priority over write-one-to-clear.
      if (go && (busy || !sel_ok))
        err <= 1'b1;
      else if (csr_wr_i && csr_addr_i == 8'd3 && csr_wrdata_i[16])
        err <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      run_auto  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      wr_sel_o  <= '0;
      wr_en_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // AUTO_INC/REPEAT come from the GO write itself.
          if (go && sel_ok) begin
            wr_addr_o <= sh_addr;
            wr_data_o <= sh_data[D_WIDTH-1:0];
            wr_sel_o  <= sh_sel[PARTS_CNT_WIDTH-1:0];
            cnt       <= csr_wrdata_i[15:8];
            run_auto  <= csr_wrdata_i[1];
            wr_en_o   <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (cnt == 8'd0) begin
            wr_en_o <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
            if (run_auto) wr_addr_o <= wr_addr_o + A_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (csr_addr_i)
      8'd0: rd_val = {16'd0, rep, 6'd0, auto_inc, busy};
      8'd1: rd_val[A_WIDTH-1:0] = sh_addr;
      8'd2: rd_val = sh_sel;
      8'd3: rd_val = {15'd0, err, commit};
      default: ;
    endcase
    for (int k = 0; k < WORDS; k++)
      if (csr_addr_i == 8'(4 + k)) rd_val = sh_data[k*32 +: 32];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      csr_rddata_o <= '0;
    else if (csr_rd_i) csr_rddata_o <= rd_val;
  end
endmodule

// File: tb/tb_qstage_ctrl_csr.sv
// Bench for qstage_ctrl_csr: vector table, hand sequences for corner cases,
// and randomized bursts checked against a beat-list reference model.
module tb_qstage_ctrl_csr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  csr_addr = '0;
  logic        csr_wr = 1'b0;
  logic [31:0] csr_wrdata = '0;
  logic        csr_rd = 1'b0;
  logic [31:0] csr_rddata;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_sel;
  logic        wr_en;

  qstage_ctrl_csr dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .csr_addr_i(csr_addr), .csr_wr_i(csr_wr), .csr_wrdata_i(csr_wrdata),
    .csr_rd_i(csr_rd), .csr_rddata_o(csr_rddata),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_sel_o(wr_sel), .wr_en_o(wr_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [1:0]  s;
    logic [63:0] d;
  } beat_t;

  beat_t act_q[$];
  beat_t exp_q[$];
  int n_pass = 0, n_tot = 0;
  int model_cnt = 0;

  always @(negedge clk)
    if (rst_n && wr_en) act_q.push_back({wr_addr, wr_sel, wr_data});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
    csr_addr = a; csr_wrdata = d; csr_wr = 1'b1;
    @(posedge clk); #1;
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
    csr_addr = a; csr_rd = 1'b1;
    @(posedge clk); #1;
    csr_rd = 1'b0;
    d = csr_rddata;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (wr_en === 1'b1 && n < 600) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 600) chk("burst timeout", 64'(n), 64'd0);
  endtask

  function automatic logic [31:0] ctrl_word(input bit go, input bit ai, input logic [7:0] r);
    return {16'd0, r, 6'd0, ai, go};
  endfunction

  // One complete burst; expected beats built from the rules, then compared.
  task automatic run_case(input string tag, input int addr, input logic [31:0] sel,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input bit ai, input int rep);
    logic [31:0] rd;
    bit exp_err;
    exp_q.delete();
    exp_err = (sel >= 4);
    if (!exp_err)
      for (int i = 0; i <= rep; i++)
        exp_q.push_back({4'((addr + (ai ? i : 0)) % 16), sel[1:0], {d1, d0}});
    model_cnt = (model_cnt + exp_q.size()) % 65536;

    csr_write(8'd3, 32'h0001_0000);
    csr_write(8'd1, 32'(addr));
    csr_write(8'd2, sel);
    csr_write(8'd4, d0);
    csr_write(8'd5, d1);
    act_q.delete();
    csr_write(8'd0, ctrl_word(1'b1, ai, 8'(rep)));
    csr_read(8'd0, rd);
    chk({tag, " busy after go"}, 64'(rd[0]), 64'(!exp_err));
    wait_idle();
    @(posedge clk); #1;
    chk({tag, " beat count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk({tag, " beat"}, 64'(act_q[i]), 64'(exp_q[i]));
    csr_read(8'd3, rd);
    chk({tag, " counter"}, 64'(rd[15:0]), 64'(model_cnt));
    chk({tag, " err"}, 64'(rd[16]), 64'(exp_err));
  endtask

  typedef struct {
    int          addr;
    logic [31:0] sel;
    logic [31:0] d0, d1;
    bit          ai;
    int          rep;
    int          exp_beats;
    logic [3:0]  exp_last;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [31:0] rd;
    int nb, need, chunk;

    vecs[0] = '{5,  32'd2, 32'hDEADBEEF, 32'h01234567, 1'b0, 0,  1,  4'd5};
    vecs[1] = '{14, 32'd1, 32'h11112222, 32'h33334444, 1'b1, 3,  4,  4'd1};
    vecs[2] = '{7,  32'd4, 32'hAAAA5555, 32'h5555AAAA, 1'b0, 2,  0,  4'd0};
    vecs[3] = '{0,  32'd3, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 15, 16, 4'd15};
    vecs[4] = '{9,  32'd0, 32'h00000001, 32'h80000000, 1'b0, 2,  3,  4'd9};

    // Reset state
    #23; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset wr_en", 64'(wr_en), 64'd0);
    chk("reset wr_addr", 64'(wr_addr), 64'd0);
    chk("reset wr_data", wr_data, 64'd0);
    chk("reset wr_sel", 64'(wr_sel), 64'd0);
    for (int r = 0; r < 6; r++) begin
      csr_read(8'(r), rd);
      chk("reset reg", 64'(rd), 64'd0);
    end
    csr_write(8'd9, 32'hFFFF_FFFF);
    csr_read(8'd9, rd);
    chk("unmapped read", 64'(rd), 64'd0);
    csr_write(8'd4, 32'hCAFE_F00D);
    csr_read(8'd4, rd);
    chk("data0 readback", 64'(rd), 64'hCAFE_F00D);

    // Vector table
    for (int v = 0; v < 5; v++) begin
      run_case("vec", vecs[v].addr, vecs[v].sel, vecs[v].d0, vecs[v].d1, vecs[v].ai, vecs[v].rep);
      chk("vec table beats", 64'(act_q.size()), 64'(vecs[v].exp_beats));
      if (vecs[v].exp_beats > 0)
        chk("vec table last addr", 64'(act_q[$].a), 64'(vecs[v].exp_last));
    end

    // BUSY duration for a 4-beat burst
    csr_write(8'd1, 32'd14);
    csr_write(8'd2, 32'd0);
    csr_write(8'd0, ctrl_word(1'b1, 1'b1, 8'd3));
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      csr_read(8'd0, rd);
      if (rd[0]) nb++; else break;
    end
    chk("busy cycles", 64'(nb), 64'd4);
    model_cnt = (model_cnt + 4) % 65536;

    // GO and ADDR write during a REPEAT=7 burst
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({4'((3 + i) % 16), 2'd1, {32'h5A5A5A5A, 32'hDEADBEEF}});
    csr_write(8'd3, 32'h0001_0000);
    csr_write(8'd1, 32'd3);
    csr_write(8'd2, 32'd1);
    csr_write(8'd4, 32'hDEADBEEF);
    csr_write(8'd5, 32'h5A5A5A5A);
    act_q.delete();
    csr_write(8'd0, ctrl_word(1'b1, 1'b1, 8'd7));
    csr_write(8'd0, ctrl_word(1'b1, 1'b1, 8'd7));
    csr_write(8'd1, 32'd12);
    wait_idle();
    @(posedge clk); #1;
    model_cnt = (model_cnt + 8) % 65536;
    chk("busy-go beats", 64'(act_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < act_q.size(); i++)
      chk("busy-go beat", 64'(act_q[i]), 64'(exp_q[i]));
    csr_read(8'd3, rd);
    chk("busy-go err", 64'(rd[16]), 64'd1);
    csr_read(8'd1, rd);
    chk("busy-go shadow addr", 64'(rd), 64'd12);
    csr_write(8'd3, 32'h0001_0000);
    csr_read(8'd3, rd);
    chk("err cleared", 64'(rd[16]), 64'd0);

    // Randomized bursts
    for (int t = 0; t < 30; t++)
      run_case("rand", int'($urandom_range(0, 15)), 32'($urandom_range(0, 4)),
               $urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)));

    // Counter wrap: run up to 0xFFFF, then one more beat
    csr_write(8'd2, 32'd0);
    need = (65535 - model_cnt) % 65536;
    while (need > 0) begin
      chunk = (need > 256) ? 256 : need;
      csr_write(8'd0, ctrl_word(1'b1, 1'b0, 8'(chunk - 1)));
      wait_idle();
      need -= chunk;
    end
    @(posedge clk); #1;
    csr_read(8'd3, rd);
    chk("counter max", 64'(rd[15:0]), 64'hFFFF);
    csr_write(8'd0, ctrl_word(1'b1, 1'b0, 8'd0));
    wait_idle();
    @(posedge clk); #1;
    csr_read(8'd3, rd);
    chk("counter wrap", 64'(rd[15:0]), 64'd0);

    // Reset at beat 3 of a REPEAT=10 burst
    csr_write(8'd1, 32'd6);
    csr_write(8'd2, 32'd3);
    csr_write(8'd0, ctrl_word(1'b1, 1'b1, 8'd10));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-burst wr_en", 64'(wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset abort wr_en", 64'(wr_en), 64'd0);
    chk("reset abort wr_addr", 64'(wr_addr), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 6; r++) begin
      csr_read(8'(r), rd);
      chk("post-reset reg", 64'(rd), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
